sprite_line_fetcher: RTL and testbench

Requester side of the sprite ROM read interface. For every scanline it scans a table of sprite slots and finds the slots whose 8-row footprint covers the next line. It issues one ROM row read per hit slot and captures the 8-bit active-low row into a shadow line buffer. At the next line_start the shadow buffer becomes the active buffer, and the block outputs per-pixel sprite coverage to the pixel mux during the visible line.

---
 rtl/sprite_line_fetcher_if.sv | 25 ++
 rtl/sprite_line_fetcher.sv | 200 ++++++++++++++++++++
 tb/tb_sprite_line_fetcher.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_line_fetcher_if.sv
// Sprite ROM read port: the fetcher strobes a row address and the ROM
// answers with an active-low 8-pixel row on the following cycle.
interface sprite_line_fetcher_if;
   logic       rom_read_enable;
   logic [3:0] rom_sprite_ID;
   logic [1:0] rom_orientation;
   logic [2:0] rom_line_index;
   logic [7:0] rom_data;

   modport master (
      output rom_read_enable,
      output rom_sprite_ID,
      output rom_orientation,
      output rom_line_index,
      input  rom_data
   );

   modport slave (
      input  rom_read_enable,
      input  rom_sprite_ID,
      input  rom_orientation,
      input  rom_line_index,
      output rom_data
   );
endinterface

// File: rtl/sprite_line_fetcher.sv
// Per-scanline sprite row fetcher: scans the slot table, reads one ROM row per
// hit slot into a shadow buffer and drives per-pixel coverage from the active one.
module sprite_line_fetcher #(
   parameter int NUM_SLOTS = 4,
   parameter int SLOT_W    = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    line_start,
   input  logic [9:0]              next_line,
   input  logic [9:0]              hpos,
   input  logic                    display_on,
   input  logic [NUM_SLOTS-1:0]    slot_valid,
   input  logic [10*NUM_SLOTS-1:0] slot_x,
   input  logic [10*NUM_SLOTS-1:0] slot_y,
   input  logic [4*NUM_SLOTS-1:0]  slot_id,
   input  logic [2*NUM_SLOTS-1:0]  slot_orient,
   sprite_line_fetcher_if.master   rom,
   output logic                    busy,
   output logic                    fetch_done,
   output logic                    pixel_on,
   output logic [SLOT_W-1:0]       pixel_slot
);

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      READ,
      CAPTURE,
      DONE
   } state_t;

   state_t               state_reg;
   logic [SLOT_W-1:0]    k_reg;
   logic [9:0]           line_reg;
   logic [NUM_SLOTS-1:0] shadow_hit_reg;
   logic [NUM_SLOTS-1:0] active_hit_reg;
   logic [7:0]           shadow_row_reg [NUM_SLOTS];
   logic [7:0]           active_row_reg [NUM_SLOTS];

   logic                 rd_en_reg;
   logic [3:0]           id_reg;
   logic [1:0]           orient_reg;
   logic [2:0]           line_idx_reg;
   logic                 busy_reg;
   logic                 done_reg;
   logic                 pixel_on_reg;
   logic [SLOT_W-1:0]    pixel_slot_reg;

   logic [NUM_SLOTS-1:0] slot_hit;
   logic [NUM_SLOTS-1:0] slot_cover;
   logic [2:0]           slot_line [NUM_SLOTS];

   // Modular subtraction makes anything above/left of the slot origin a miss.
   generate
      for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
         logic [9:0] row;
         logic [9:0] col;
         assign row            = line_reg - slot_y[10*gi +: 10];
         assign slot_hit[gi]   = slot_valid[gi] && (row[9:3] == 7'd0);
         assign slot_line[gi]  = row[2:0];
         assign col            = hpos - slot_x[10*gi +: 10];
         assign slot_cover[gi] = active_hit_reg[gi] && (col[9:3] == 7'd0) &&
                                 !active_row_reg[gi][3'd7 - col[2:0]];
      end
   endgenerate

   logic                 cur_hit;
   logic [2:0]           cur_line;
   logic [3:0]           cur_id;
   logic [1:0]           cur_orient;
   logic                 last_slot;

   always_comb begin
      cur_hit    = 1'b0;
      cur_line   = 3'd0;
      cur_id     = 4'd0;
      cur_orient = 2'd0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (k_reg == SLOT_W'(i)) begin
            cur_hit    = slot_hit[i];
            cur_line   = slot_line[i];
            cur_id     = slot_id[4*i +: 4];
            cur_orient = slot_orient[2*i +: 2];
         end
      end
   end

   assign last_slot = (k_reg == SLOT_W'(NUM_SLOTS - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         k_reg          <= '0;
         line_reg       <= '0;
         shadow_hit_reg <= '0;
         active_hit_reg <= '0;
         rd_en_reg      <= 1'b0;
         id_reg         <= '0;
         orient_reg     <= '0;
         line_idx_reg   <= '0;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            shadow_row_reg[i] <= 8'hFF;
            active_row_reg[i] <= 8'hFF;
         end
      end else begin
         rd_en_reg <= 1'b0;
         done_reg  <= 1'b0;
         // line_start preempts any fetch still in flight; its response is dropped.
         if (line_start) begin
            active_row_reg <= shadow_row_reg;
            active_hit_reg <= shadow_hit_reg;
            shadow_hit_reg <= '0;
            line_reg       <= next_line;
            k_reg          <= '0;
            state_reg      <= SCAN;
            busy_reg       <= 1'b1;
         end else begin
            case (state_reg)
               SCAN: begin
                  if (cur_hit) begin
                     id_reg       <= cur_id;
                     orient_reg   <= cur_orient;
                     line_idx_reg <= cur_line;
                     rd_en_reg    <= 1'b1;
                     state_reg    <= READ;
                  end else if (last_slot) begin
                     done_reg  <= 1'b1;
                     state_reg <= DONE;
                  end else begin
                     k_reg <= k_reg + SLOT_W'(1);
                  end
               end
               READ: begin
                  state_reg <= CAPTURE;
               end
               CAPTURE: begin
                  for (int i = 0; i < NUM_SLOTS; i++) begin
                     if (k_reg == SLOT_W'(i)) begin
                        shadow_row_reg[i] <= rom.rom_data;
                        shadow_hit_reg[i] <= 1'b1;
                     end
                  end
                  if (last_slot) begin
                     done_reg  <= 1'b1;
                     state_reg <= DONE;
                  end else begin
                     k_reg     <= k_reg + SLOT_W'(1);
                     state_reg <= SCAN;
                  end
               end
               DONE: begin
                  busy_reg  <= 1'b0;
                  state_reg <= IDLE;
               end
               default: begin
                  state_reg <= IDLE;
               end
            endcase
         end
      end
   end

   logic              any_cover;
   logic [SLOT_W-1:0] win_slot;

   // Scan downwards so the lowest covering slot is the one left standing.
   always_comb begin
      any_cover = 1'b0;
      win_slot  = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (slot_cover[i]) begin
            any_cover = 1'b1;
            win_slot  = SLOT_W'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pixel_on_reg   <= 1'b0;
         pixel_slot_reg <= '0;
      end else begin
         pixel_on_reg   <= display_on && any_cover;
         pixel_slot_reg <= win_slot;
      end
   end

   assign rom.rom_read_enable = rd_en_reg;
   assign rom.rom_sprite_ID   = id_reg;
   assign rom.rom_orientation = orient_reg;
   assign rom.rom_line_index  = line_idx_reg;
   assign busy                = busy_reg;
   assign fetch_done          = done_reg;
   assign pixel_on            = pixel_on_reg;
   assign pixel_slot          = pixel_slot_reg;

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Randomized bench for sprite_line_fetcher against a slot-table / line-buffer
// reference model with a one-cycle-latency ROM stub.
module tb_sprite_line_fetcher;
   localparam int N  = 4;
   localparam int SW = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            reset;
   logic            line_start;
   logic [9:0]      next_line;
   logic [9:0]      hpos;
   logic            display_on;
   logic [N-1:0]    slot_valid;
   logic [10*N-1:0] slot_x;
   logic [10*N-1:0] slot_y;
   logic [4*N-1:0]  slot_id;
   logic [2*N-1:0]  slot_orient;
   logic            busy;
   logic            fetch_done;
   logic            pixel_on;
   logic [SW-1:0]   pixel_slot;

   sprite_line_fetcher_if rom_bus ();

   sprite_line_fetcher #(.NUM_SLOTS(N), .SLOT_W(SW)) dut (
      .clk         (clk),
      .reset       (reset),
      .line_start  (line_start),
      .next_line   (next_line),
      .hpos        (hpos),
      .display_on  (display_on),
      .slot_valid  (slot_valid),
      .slot_x      (slot_x),
      .slot_y      (slot_y),
      .slot_id     (slot_id),
      .slot_orient (slot_orient),
      .rom         (rom_bus.master),
      .busy        (busy),
      .fetch_done  (fetch_done),
      .pixel_on    (pixel_on),
      .pixel_slot  (pixel_slot)
   );

   // Slot table as seen by the bench
   logic       tv  [N];
   logic [9:0] tx  [N];
   logic [9:0] ty  [N];
   logic [3:0] tid [N];
   logic [1:0] tor [N];

   always_comb begin
      slot_valid  = '0;
      slot_x      = '0;
      slot_y      = '0;
      slot_id     = '0;
      slot_orient = '0;
      for (int k = 0; k < N; k++) begin
         slot_valid[k]        = tv[k];
         slot_x[10*k +: 10]   = tx[k];
         slot_y[10*k +: 10]   = ty[k];
         slot_id[4*k +: 4]    = tid[k];
         slot_orient[2*k +: 2] = tor[k];
      end
   end

   // ROM content; with orientation 0 this is {id, 0, line}
   function automatic logic [7:0] rom_fn(input logic [3:0] id, input logic [1:0] o,
                                         input logic [2:0] l);
      return {id ^ {2'b00, o}, |o, l};
   endfunction

   // Outside a strobe response the data bus carries noise
   always @(posedge clk) begin
      if (rom_bus.rom_read_enable)
         rom_bus.rom_data <= rom_fn(rom_bus.rom_sprite_ID, rom_bus.rom_orientation,
                                    rom_bus.rom_line_index);
      else
         rom_bus.rom_data <= 8'($urandom);
   end

   // Reference line buffers
   logic       m_sh_hit  [N];
   logic       m_act_hit [N];
   logic [7:0] m_sh_row  [N];
   logic [7:0] m_act_row [N];

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int k = 0; k < N; k++) begin
         m_sh_hit[k]  = 1'b0;
         m_act_hit[k] = 1'b0;
         m_sh_row[k]  = 8'hFF;
         m_act_row[k] = 8'hFF;
      end
   endfunction

   function automatic void model_line_start();
      for (int k = 0; k < N; k++) begin
         m_act_hit[k] = m_sh_hit[k];
         m_act_row[k] = m_sh_row[k];
         m_sh_hit[k]  = 1'b0;
      end
   endfunction

   task automatic set_slot(input int k, input logic v, input int x, input int y,
                           input int id, input int o);
      tv[k]  = v;
      tx[k]  = 10'(x);
      ty[k]  = 10'(y);
      tid[k] = 4'(id);
      tor[k] = 2'(o);
   endtask

   task automatic clear_slots();
      for (int k = 0; k < N; k++) set_slot(k, 1'b0, 0, 0, 0, 0);
   endtask

   // Pulse line_start with nl and follow the fetch cycle by cycle. A nonzero
   // abort_at returns at that cycle so the caller can issue the next line_start.
   task automatic fetch_line(input logic [9:0] nl, input int abort_at);
      int         stb [N];
      logic       hit [N];
      logic [9:0] row [N];
      int         t, done_cyc, ab, nhit, ek, last;
      logic       exp_rd;
      t    = 1;
      nhit = 0;
      for (int k = 0; k < N; k++) begin
         row[k] = nl - ty[k];
         hit[k] = tv[k] && (row[k] < 10'd8);
         if (hit[k]) begin
            stb[k] = t + 1;
            t      = t + 3;
            nhit++;
         end else begin
            stb[k] = -1;
            t      = t + 1;
         end
      end
      done_cyc = t;
      ab       = (abort_at > done_cyc) ? 0 : abort_at;
      last     = (ab > 0) ? ab : done_cyc + 1;
      model_line_start();
      line_start = 1'b1;
      next_line  = nl;
      @(negedge clk);
      line_start = 1'b0;
      for (int c = 1; c <= last; c++) begin
         exp_rd = 1'b0;
         ek     = 0;
         for (int k = 0; k < N; k++) begin
            if (hit[k] && stb[k] == c) begin
               exp_rd = 1'b1;
               ek     = k;
            end
         end
         check_eq("rom_read_enable", rom_bus.rom_read_enable, exp_rd);
         check_eq("fetch_done", fetch_done, c == done_cyc);
         check_eq("busy", busy, c <= done_cyc);
         if (exp_rd) begin
            check_eq("rom_sprite_ID", rom_bus.rom_sprite_ID, tid[ek]);
            check_eq("rom_orientation", rom_bus.rom_orientation, tor[ek]);
            check_eq("rom_line_index", rom_bus.rom_line_index, row[ek][2:0]);
         end
         if (c != ab) @(negedge clk);
      end
      for (int k = 0; k < N; k++) begin
         if (hit[k] && (ab == 0 || stb[k] + 1 < ab)) begin
            m_sh_hit[k] = 1'b1;
            m_sh_row[k] = rom_fn(tid[k], tor[k], row[k][2:0]);
         end
      end
      $display("line %0d: hit slots=%0d done_cycle=%0d abort_cycle=%0d", nl, nhit, done_cyc, ab);
   endtask

   // Drive one pixel column and compare the registered result one cycle later
   task automatic pix_check(input logic [9:0] h, input logic d);
      logic          eon;
      logic [SW-1:0] es;
      logic [9:0]    col;
      int            idx;
      hpos       = h;
      display_on = d;
      @(negedge clk);
      eon = 1'b0;
      es  = '0;
      for (int k = 0; k < N; k++) begin
         col = h - tx[k];
         idx = 7 - int'(col[2:0]);
         if (!eon && m_act_hit[k] && col < 10'd8 && m_act_row[k][idx] == 1'b0) begin
            eon = 1'b1;
            es  = SW'(k);
         end
      end
      check_eq("pixel_on", pixel_on, d & eon);
      if (d) check_eq("pixel_slot", pixel_slot, es);
   endtask

   task automatic sweep(input int lo, input int hi);
      for (int h = lo; h <= hi; h++) pix_check(10'(h), 1'b1);
      $display("pixel sweep hpos %0d..%0d", lo, hi);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nl, ab;
      reset      = 1'b1;
      line_start = 1'b0;
      next_line  = '0;
      hpos       = '0;
      display_on = 1'b0;
      clear_slots();
      model_reset();
      repeat (3) @(negedge clk);
      check_eq("reset busy", busy, 1'b0);
      check_eq("reset fetch_done", fetch_done, 1'b0);
      check_eq("reset pixel_on", pixel_on, 1'b0);
      check_eq("reset pixel_slot", pixel_slot, 0);
      check_eq("reset rom_read_enable", rom_bus.rom_read_enable, 1'b0);
      check_eq("reset rom_sprite_ID", rom_bus.rom_sprite_ID, 0);
      check_eq("reset rom_orientation", rom_bus.rom_orientation, 0);
      check_eq("reset rom_line_index", rom_bus.rom_line_index, 0);
      reset = 1'b0;
      @(negedge clk);

      // Four hits on one line
      for (int k = 0; k < N; k++) set_slot(k, 1'b1, 40 + 20 * k, 100, k + 1, 0);
      fetch_line(10'd103, 0);

      // One hit, one modular miss (row 1021)
      clear_slots();
      set_slot(0, 1'b1, 40, 50, 9, 0);
      set_slot(2, 1'b1, 80, 60, 10, 0);
      fetch_line(10'd57, 0);

      // Row 0111_1110 at x = 200
      clear_slots();
      set_slot(0, 1'b1, 200, 10, 6, 1);
      fetch_line(10'd16, 0);
      fetch_line(10'd17, 0);
      sweep(198, 209);
      pix_check(10'd200, 1'b0);

      // Overlapping slots around hpos 300
      clear_slots();
      set_slot(0, 1'b1, 100, 10, 2, 0);
      set_slot(1, 1'b1, 300, 10, 3, 0);
      set_slot(2, 1'b1, 296, 12, 5, 0);
      set_slot(3, 1'b1, 300, 10, 4, 2);
      fetch_line(10'd15, 0);
      fetch_line(10'd15, 0);
      sweep(294, 310);

      // line_start during the READ of slot 1, then a fresh scan
      for (int k = 0; k < N; k++) set_slot(k, 1'b1, 40 + 20 * k, 100, k + 1, 0);
      fetch_line(10'd103, 5);
      fetch_line(10'd104, 0);
      sweep(36, 108);

      // Reset in the middle of a fetch
      hpos       = 10'd40;
      display_on = 1'b1;
      model_line_start();
      line_start = 1'b1;
      next_line  = 10'd103;
      @(negedge clk);
      line_start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_eq("pre-reset pixel_on", pixel_on, m_act_hit[0] & ~m_act_row[0][7]);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      check_eq("mid reset busy", busy, 1'b0);
      check_eq("mid reset rom_read_enable", rom_bus.rom_read_enable, 1'b0);
      check_eq("mid reset pixel_on", pixel_on, 1'b0);
      check_eq("mid reset fetch_done", fetch_done, 1'b0);
      pix_check(10'd40, 1'b1);
      fetch_line(10'd103, 0);
      sweep(36, 50);
      fetch_line(10'd103, 0);
      sweep(36, 50);

      // Randomized slot tables, aborts and pixel columns
      for (int it = 0; it < 30; it++) begin
         nl = $urandom_range(20, 1000);
         for (int k = 0; k < N; k++) begin
            set_slot(k, $urandom_range(0, 3) != 0, $urandom_range(8, 60),
                     nl - $urandom_range(0, 12), $urandom, $urandom);
         end
         ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 14) : 0;
         fetch_line(10'(nl), ab);
         if (ab != 0) fetch_line(10'(nl + 1), 0);
         for (int p = 0; p < 16; p++)
            pix_check(10'($urandom_range(0, 80)), $urandom_range(0, 3) != 0);
         $display("random iteration %0d done", it);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
